// File: rtl/ap_pkg.sv
// Shared definitions for the associative-processor cell array: opcodes,
// sweep FSM states and the row-slice helper used to address the packed image.
package ap_pkg;

  localparam logic [2:0] AP_OP_NOP    = 3'd0;
  localparam logic [2:0] AP_OP_WR_ROW = 3'd1;
  localparam logic [2:0] AP_OP_WR_COL = 3'd2;
  localparam logic [2:0] AP_OP_RD_ROW = 3'd3;
  localparam logic [2:0] AP_OP_RD_COL = 3'd4;
  localparam logic [2:0] AP_OP_LOAD   = 3'd5;
  localparam logic [2:0] AP_OP_TAG_WR = 3'd6;
  localparam logic [2:0] AP_OP_CLEAR  = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } ap_state_t;

  // Lowest bit index of row 'row' in an image packed row-major with 'width' bits per row.
  function automatic int row_lo(input int row, input int width);
    return row * width;
  endfunction

endpackage

// File: rtl/ap_col_mux.sv
// Combinational column extractor: picks bit 'col' of every row of a packed
// bit matrix. An out-of-range column yields all zeros.
module ap_col_mux
  import ap_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic [DATA_WIDTH*DATA_DEPTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0]            col,
  output logic [DATA_DEPTH-1:0]            col_bits
);

  always_comb begin
    col_bits = '0;
    for (int r = 0; r < DATA_DEPTH; r++) begin
      for (int c = 0; c < DATA_WIDTH; c++) begin
        if (int'(col) == c) begin
          col_bits[r] = data[row_lo(r, DATA_WIDTH) + c];
        end
      end
    end
  end

endmodule

// File: rtl/ap_cell_array.sv
// Bit-matrix result/operand array with row/column access, masked tag writes,
// whole-array load and a one-row-per-cycle clear sweep. Define AP_ABS_EN to add
// the per-row 'sign' input that inverts tag-write data for the absolute-value pass.
module ap_cell_array
  import ap_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int DATA_DEPTH     = 16,
  parameter int ADDR_WIDTH_CAM = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [2:0]                       cmd_op,
  input  logic [ADDR_WIDTH_CAM-1:0]        cmd_addr,
  input  logic [DATA_WIDTH-1:0]            wr_row,
  input  logic [DATA_DEPTH-1:0]            wr_col,
  input  logic [DATA_DEPTH-1:0]            tag,
  input  logic [DATA_WIDTH-1:0]            mask,
  input  logic [DATA_WIDTH*DATA_DEPTH-1:0] load_data,
`ifdef AP_ABS_EN
  input  logic [DATA_DEPTH-1:0]            sign,
`endif
  output logic                             rd_valid,
  output logic [DATA_WIDTH-1:0]            rd_row,
  output logic [DATA_DEPTH-1:0]            rd_col,
  output logic                             cmd_err,
  output logic [DATA_WIDTH*DATA_DEPTH-1:0] Q
);

  localparam int CNT_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(DATA_DEPTH - 1);

  ap_state_t state, next_state;
  logic [CNT_W-1:0] sweep_cnt;
  logic [DATA_WIDTH*DATA_DEPTH-1:0] q, q_next;
  logic accept, row_ok, col_ok, is_row_op, is_col_op, addr_bad;
  logic [DATA_WIDTH-1:0] row_sel;
  logic [DATA_DEPTH-1:0] col_sel;

  assign accept    = cmd_valid && cmd_ready;
  assign row_ok    = int'(cmd_addr) < DATA_DEPTH;
  assign col_ok    = int'(cmd_addr) < DATA_WIDTH;
  assign is_row_op = (cmd_op == AP_OP_WR_ROW) || (cmd_op == AP_OP_RD_ROW);
  assign is_col_op = (cmd_op == AP_OP_WR_COL) || (cmd_op == AP_OP_RD_COL);
  assign addr_bad  = (is_row_op && !row_ok) || (is_col_op && !col_ok);
  assign Q         = q;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // cmd_valid is used directly here so the ready/accept path stays acyclic.
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && (cmd_op == AP_OP_CLEAR)) next_state = ST_SWEEP;
      end
      ST_SWEEP: begin
        if (sweep_cnt == LAST_ROW) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                    sweep_cnt <= '0;
    else if (state == ST_SWEEP) sweep_cnt <= (sweep_cnt == LAST_ROW) ? '0 : sweep_cnt + 1'b1;
  end

  always_comb begin
    row_sel = '0;
    for (int r = 0; r < DATA_DEPTH; r++) begin
      if (int'(cmd_addr) == r) row_sel = q[row_lo(r, DATA_WIDTH) +: DATA_WIDTH];
    end
  end

  ap_col_mux #(
    .DATA_WIDTH(DATA_WIDTH),
    .DATA_DEPTH(DATA_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH_CAM)
  ) u_col_mux (
    .data    (q),
    .col     (cmd_addr),
    .col_bits(col_sel)
  );

  // Commands are never accepted during a sweep, so the two write sources never collide.
  always_comb begin
    q_next = q;
    if (state == ST_SWEEP) begin
      for (int r = 0; r < DATA_DEPTH; r++) begin
        if (int'(sweep_cnt) == r) q_next[row_lo(r, DATA_WIDTH) +: DATA_WIDTH] = '0;
      end
    end else if (accept && !addr_bad) begin
      case (cmd_op)
        AP_OP_WR_ROW: begin
          for (int r = 0; r < DATA_DEPTH; r++) begin
            if (int'(cmd_addr) == r) q_next[row_lo(r, DATA_WIDTH) +: DATA_WIDTH] = wr_row;
          end
        end
        AP_OP_WR_COL: begin
          for (int r = 0; r < DATA_DEPTH; r++) begin
            for (int c = 0; c < DATA_WIDTH; c++) begin
              if (int'(cmd_addr) == c) q_next[row_lo(r, DATA_WIDTH) + c] = wr_col[r];
            end
          end
        end
        AP_OP_LOAD: q_next = load_data;
        AP_OP_TAG_WR: begin
          for (int r = 0; r < DATA_DEPTH; r++) begin
            for (int c = 0; c < DATA_WIDTH; c++) begin
              if (tag[r] && mask[c]) begin
`ifdef AP_ABS_EN
                q_next[row_lo(r, DATA_WIDTH) + c] = wr_row[c] ^ sign[r];
`else
                q_next[row_lo(r, DATA_WIDTH) + c] = wr_row[c];
`endif
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= q_next;
  end

  // Reads sample the pre-write array; out-of-range reads still complete, with zero data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_row   <= '0;
      rd_col   <= '0;
      cmd_err  <= 1'b0;
    end else begin
      rd_valid <= accept && ((cmd_op == AP_OP_RD_ROW) || (cmd_op == AP_OP_RD_COL));
      cmd_err  <= accept && addr_bad;
      if (accept && (cmd_op == AP_OP_RD_ROW)) rd_row <= row_ok ? row_sel : '0;
      if (accept && (cmd_op == AP_OP_RD_COL)) rd_col <= col_ok ? col_sel : '0;
    end
  end

endmodule

// File: doc/ap_cell_array.md
Name: ap_cell_array

Overview:
Parametrised bit-matrix storage array for the associative processor: DATA_DEPTH rows × DATA_WIDTH bits, with row-wise and column-wise (transposed) read/write. Adds masked tag-parallel writes, a whole-array load, and a multi-cycle row-sweep clear. Commands use a valid/ready handshake and reads return with registered fixed latency. Sits between the AP controller and the CAM/tag logic, as the next-generation result/operand array.

Parameters:
DATA_WIDTH, 16, bits per row (columns)
DATA_DEPTH, 16, rows
ADDR_WIDTH_CAM, 8, width of cmd_addr; must satisfy 2**ADDR_WIDTH_CAM >= max(DATA_WIDTH, DATA_DEPTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  array can accept command this cycle
cmd_op  in  3  opcode (see Behaviour)
cmd_addr  in  ADDR_WIDTH_CAM  row index (row ops) or column index (column ops)
wr_row  in  DATA_WIDTH  row write data / tag-write data
wr_col  in  DATA_DEPTH  column write data, bit r → row r
tag  in  DATA_DEPTH  row select for TAG_WR
mask  in  DATA_WIDTH  column enable for TAG_WR
load_data  in  DATA_WIDTH*DATA_DEPTH  full-array image, row r at [r*DATA_WIDTH +: DATA_WIDTH]
rd_valid  out  1  read data valid pulse
rd_row  out  DATA_WIDTH  row read data
rd_col  out  DATA_DEPTH  column read data
cmd_err  out  1  one-cycle pulse: accepted command had out-of-range address
Q  out  DATA_WIDTH*DATA_DEPTH  registered full-array contents, same packing as load_data

Behaviour:
- Opcodes: 0 NOP, 1 WR_ROW, 2 WR_COL, 3 RD_ROW, 4 RD_COL, 5 LOAD, 6 TAG_WR, 7 CLEAR.
- A command is accepted when cmd_valid && cmd_ready at a rising clk edge.
- Reset: Q=0, rd_row=0, rd_col=0, rd_valid=0, cmd_err=0, FSM=IDLE, cmd_ready=1 the cycle after rst deasserts. rst overrides everything, including a CLEAR in progress.
- FSM states: IDLE and SWEEP.
  - IDLE: cmd_ready=1.
  - CLEAR accepted → SWEEP. cmd_ready=0.
  - SWEEP: zero row sweep_cnt each cycle, rows 0..DATA_DEPTH-1, DATA_DEPTH cycles total.
  - After the last row → IDLE. cmd_ready returns high the cycle after the last row clears.
- Writes take effect on the accepting edge; Q reflects them in the next cycle.
  - WR_ROW: row cmd_addr ← wr_row.
  - WR_COL: bit cmd_addr of every row r ← wr_col[r].
  - LOAD: Q ← load_data.
  - TAG_WR: for every r with tag[r]=1 and every c with mask[c]=1, Q[r][c] ← wr_row[c]; other bits hold.
- Reads:
  - RD_ROW: rd_row ← row cmd_addr, rd_valid=1 exactly one cycle after acceptance (latency 1).
  - RD_COL: rd_col[r] ← Q[r][cmd_addr], same latency.
  - Read data reflects the array before any write in the same cycle; only one command is accepted per cycle.
  - rd_row/rd_col hold their last value when rd_valid=0.
- Out of range:
  - Row ops with cmd_addr >= DATA_DEPTH, or column ops with cmd_addr >= DATA_WIDTH: no array change.
  - Reads: rd_valid=1 with zero data.
  - cmd_err=1 one cycle after acceptance.
- NOP is accepted with no effect. tag=0 or mask=0 makes TAG_WR a no-op (no error).
- Back-to-back commands at one per cycle are supported in IDLE, e.g. WR_ROW then RD_ROW of the same row returns the new data.

Optional Feature:
AP_ABS_EN.
- Defined: adds input port sign in DATA_DEPTH. During TAG_WR, tagged rows with sign[r]=1 are written with ~wr_row[c] (masked bits only); sign[r]=0 rows are written with wr_row. This supports the absolute-value pass.
- Undefined: sign port absent; TAG_WR always writes non-inverted data.

Decomposition:
- Shared package ap_pkg: opcode constants (AP_OP_NOP … AP_OP_CLEAR), FSM state encoding, and a row-slice index function.
- Sub-module ap_col_mux: combinational column extractor (DATA_DEPTH × DATA_WIDTH → DATA_DEPTH bits by column index). It is reused by the CAM search logic.

Test Plan:
- Reset then RD_ROW addr 3 → rd_valid one cycle later, rd_row=0, cmd_ready=1.
- WR_ROW addr 2 data 0xA5C3, then RD_COL addr 0 → rd_col bit2=1 (0xA5C3 bit0=1), other bits 0; RD_ROW 2 → 0xA5C3.
- LOAD all-ones, TAG_WR tag=0x0005, mask=0x00FF, wr_row=0x0000 → rows 0,2 = 0xFF00, row 1 = 0xFFFF. With AP_ABS_EN and sign=0x0004: row 0 = 0xFF00, row 2 = 0xFFFF.
- CLEAR after LOAD 0xFFFF…; cmd_valid held high with RD_ROW 5 → cmd_ready low 16 cycles, read accepted after sweep, rd_row=0.
- Assert rst on sweep cycle 7 → next cycle cmd_ready=1, Q=0, FSM IDLE.
- WR_ROW addr 20 (DEPTH 16) → Q unchanged, cmd_err pulse; RD_COL addr 16 → rd_valid with rd_col=0, cmd_err pulse.
